mole_sequencer: RTL

Game-side producer for the mole VGA renderer. It runs the round state machine, chooses which of the five ovals shows the mole, and times how long the mole stays up and down. It also edge-detects the five player buttons, scores hits and counts misses. Its `oval_select`/`mole_visible` outputs drive the display block's oval selection; `score` and `misses` feed the HUD.

---
 rtl/mole_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mole_sequencer.sv
// mole_sequencer: round FSM, oval picker, up/down timer and hit scoring
// for the whack-a-mole game; drives the renderer and the HUD counters.
module mole_sequencer #(
   parameter int unsigned UP_CYCLES   = 50_000_000,
   parameter int unsigned DOWN_CYCLES = 25_000_000,
   parameter int unsigned MAX_MISSES  = 5,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] hit_btn,
   output logic [2:0] oval_select,
   output logic       mole_visible,
   output logic [7:0] score,
   output logic [7:0] misses,
   output logic       hit_pulse,
   output logic       miss_pulse,
   output logic       game_over
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIDE,
      S_SHOW,
      S_OVER
   } state_t;

   localparam logic [25:0] LP_UP_LD = 26'(UP_CYCLES - 1);
   localparam logic [25:0] LP_DN_LD = 26'(DOWN_CYCLES - 1);
   localparam logic [8:0]  LP_MAX   = 9'(MAX_MISSES);

   state_t      r_state;
   logic [25:0] r_timer;
   logic [7:0]  r_lfsr;
   logic [4:0]  r_btn_prev;
   logic [2:0]  r_oval;
   logic        r_vis;
   logic [7:0]  r_score;
   logic [7:0]  r_misses;
   logic        r_hit_pulse;
   logic        r_miss_pulse;
   logic        r_over;

   state_t      w_state_nxt;
   logic [25:0] w_timer_nxt;
   logic [7:0]  w_lfsr_nxt;
   logic [2:0]  w_oval_nxt;
   logic        w_vis_nxt;
   logic [7:0]  w_score_nxt;
   logic [7:0]  w_misses_nxt;
   logic        w_hit_pulse_nxt;
   logic        w_miss_pulse_nxt;
   logic        w_over_nxt;

   logic [4:0]  w_edge;
   logic [4:0]  w_sel;
   logic        w_hit;
   logic        w_expire;
   logic [8:0]  w_miss_inc;
   logic [2:0]  w_pick;
   logic [2:0]  w_new_oval;

   assign w_lfsr_nxt = {r_lfsr[6:0],
                        r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   assign w_edge     = hit_btn & ~r_btn_prev;
   assign w_sel      = 5'b00001 << (r_oval - 3'd1);
   assign w_hit      = (r_state == S_SHOW) && (|(w_edge & w_sel));
   assign w_expire   = (r_timer == 26'd0);
   assign w_miss_inc = {1'b0, r_misses} + 9'd1;

   // map the low LFSR bits onto 1..5 and step past the current oval
   always_comb begin
      w_pick = 3'd1;
      unique case (r_lfsr[2:0])
         3'd0: w_pick = 3'd1;
         3'd1: w_pick = 3'd2;
         3'd2: w_pick = 3'd3;
         3'd3: w_pick = 3'd4;
         3'd4: w_pick = 3'd5;
         3'd5: w_pick = 3'd1;
         3'd6: w_pick = 3'd2;
         3'd7: w_pick = 3'd3;
      endcase
      w_new_oval = w_pick;
      if (w_pick == r_oval)
         w_new_oval = (w_pick == 3'd5) ? 3'd1 : w_pick + 3'd1;
   end

   // round FSM: next state, timer reload and scoreboard updates
   always_comb begin
      w_state_nxt      = r_state;
      w_timer_nxt      = w_expire ? r_timer : r_timer - 26'd1;
      w_oval_nxt       = r_oval;
      w_vis_nxt        = r_vis;
      w_score_nxt      = r_score;
      w_misses_nxt     = r_misses;
      w_hit_pulse_nxt  = 1'b0;
      w_miss_pulse_nxt = 1'b0;
      w_over_nxt       = r_over;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_HIDE;
               w_timer_nxt = LP_DN_LD;
            end
         end
         S_HIDE: begin
            if (w_expire) begin
               w_state_nxt = S_SHOW;
               w_timer_nxt = LP_UP_LD;
               w_oval_nxt  = w_new_oval;
               w_vis_nxt   = 1'b1;
            end
         end
         S_SHOW: begin
            if (w_hit) begin
               w_state_nxt     = S_HIDE;
               w_timer_nxt     = LP_DN_LD;
               w_vis_nxt       = 1'b0;
               w_hit_pulse_nxt = 1'b1;
               if (r_score != 8'hFF)
                  w_score_nxt = r_score + 8'd1;
            end else if (w_expire) begin
               w_vis_nxt        = 1'b0;
               w_miss_pulse_nxt = 1'b1;
               w_misses_nxt     = w_miss_inc[7:0];
               if (w_miss_inc == LP_MAX) begin
                  w_state_nxt = S_OVER;
                  w_over_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_HIDE;
                  w_timer_nxt = LP_DN_LD;
               end
            end
         end
         S_OVER: begin
            if (start) begin
               w_state_nxt  = S_HIDE;
               w_timer_nxt  = LP_DN_LD;
               w_score_nxt  = 8'd0;
               w_misses_nxt = 8'd0;
               w_over_nxt   = 1'b0;
            end
         end
      endcase
   end

   // state and datapath registers; LFSR and button history run every cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_timer      <= 26'd0;
         r_lfsr       <= LFSR_SEED;
         r_btn_prev   <= 5'd0;
         r_oval       <= 3'd1;
         r_vis        <= 1'b0;
         r_score      <= 8'd0;
         r_misses     <= 8'd0;
         r_hit_pulse  <= 1'b0;
         r_miss_pulse <= 1'b0;
         r_over       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_lfsr       <= w_lfsr_nxt;
         r_btn_prev   <= hit_btn;
         r_oval       <= w_oval_nxt;
         r_vis        <= w_vis_nxt;
         r_score      <= w_score_nxt;
         r_misses     <= w_misses_nxt;
         r_hit_pulse  <= w_hit_pulse_nxt;
         r_miss_pulse <= w_miss_pulse_nxt;
         r_over       <= w_over_nxt;
      end
   end

   assign oval_select  = r_oval;
   assign mole_visible = r_vis;
   assign score        = r_score;
   assign misses       = r_misses;
   assign hit_pulse    = r_hit_pulse;
   assign miss_pulse   = r_miss_pulse;
   assign game_over    = r_over;

endmodule
